// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand load / start controls in, product and status out.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Din;
    logic             Load_B;
    logic             Clr_A;
    logic             Start;
    logic             Signed_Mode;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic             X_out;
    logic             Busy;
    logic             Done;

    modport master (
        output Din, Load_B, Clr_A, Start, Signed_Mode,
        input  A_out, B_out, X_out, Busy, Done
    );

    modport slave (
        input  Din, Load_B, Clr_A, Start, Signed_Mode,
        output A_out, B_out, X_out, Busy, Done
    );
endinterface

// File: rtl/shift_add_multiplier_add_sub_unit.sv
// Combinational (WIDTH+1)-bit adder/subtractor; sign- or zero-extends both operands.
// Carry/borrow beyond the extension bit is discarded.
module add_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] S,
    input  logic             Sub,
    input  logic             Sign_Ext,
    output logic [WIDTH:0]   Sum
);
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] s_ext;

    assign a_ext = {Sign_Ext & A[WIDTH-1], A};
    assign s_ext = {Sign_Ext & S[WIDTH-1], S};
    assign Sum   = Sub ? (a_ext - s_ext) : (a_ext + s_ext);
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's complement, product in {A_out,B_out}.
// Latency: 2*WIDTH cycles from the Start edge to Done, independent of operands.
// No backpressure: HOLD keeps the product until Start is seen low.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    shift_add_multiplier_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("shift_add_multiplier: WIDTH out of range");
    end

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] s_reg;
    logic             mode;
    logic             x_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH:0]   sum;

    // Signed runs subtract on the multiplier's sign bit (Booth-style correction).
    add_sub_unit #(.WIDTH(WIDTH)) u_add_sub (
        .A        (a_reg),
        .S        (s_reg),
        .Sub      (mode && (count == LAST)),
        .Sign_Ext (mode),
        .Sum      (sum)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
            s_reg <= '0;
            mode  <= 1'b0;
            x_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        s_reg <= bus.Din;
                        mode  <= bus.Signed_Mode;
                        x_reg <= 1'b0;
                        a_reg <= '0;
                        count <= '0;
                        state <= ADD;
                    end else begin
                        if (bus.Load_B) b_reg <= bus.Din;
                        if (bus.Clr_A) begin
                            x_reg <= 1'b0;
                            a_reg <= '0;
                        end
                    end
                end
                ADD: begin
                    if (b_reg[0]) {x_reg, a_reg} <= sum;
                    state <= SHIFT;
                end
                SHIFT: begin
                    x_reg <= mode & x_reg;
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    if (count == LAST) begin
                        state <= HOLD;
                    end else begin
                        count <= count + 1'b1;
                        state <= ADD;
                    end
                end
                HOLD: begin
                    if (!bus.Start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A_out = a_reg;
    assign bus.B_out = b_reg;
    assign bus.X_out = x_reg;
    assign bus.Busy  = (state == ADD) || (state == SHIFT);
    assign bus.Done  = (state == HOLD);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier against an arithmetic reference.
module tb_shift_add_multiplier;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] s, input logic [W-1:0] b,
                                                 input logic sm);
        longint ls, lb;
        if (sm) begin
            ls = longint'($signed(s));
            lb = longint'($signed(b));
        end else begin
            ls = longint'(s);
            lb = longint'(b);
        end
        return (2*W)'(ls * lb);
    endfunction

    // Reference: idle / busy-for-2W-cycles / hold, with the product appearing on entry to hold.
    int             m_phase = 0;
    int             m_left = 0;
    logic [W-1:0]   m_a = '0, m_b = '0, m_s = '0;
    logic           m_x = 1'b0, m_mode = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_x     <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.Start) begin
                        m_s     <= bus.Din;
                        m_mode  <= bus.Signed_Mode;
                        m_a     <= '0;
                        m_x     <= 1'b0;
                        m_left  <= 2*W;
                        m_phase <= 1;
                    end else begin
                        if (bus.Load_B) m_b <= bus.Din;
                        if (bus.Clr_A) begin
                            m_a <= '0;
                            m_x <= 1'b0;
                        end
                    end
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        {m_a, m_b} <= ref_prod(m_s, m_b, m_mode);
                        m_x        <= m_mode & ref_prod(m_s, m_b, m_mode)[2*W-1];
                        m_phase    <= 2;
                    end
                end
                default: if (!bus.Start) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(bus.Busy), 64'(m_phase == 1));
            chk("done", 64'(bus.Done), 64'(m_phase == 2));
            if (m_phase != 1) begin
                chk("a_out", 64'(bus.A_out), 64'(m_a));
                chk("b_out", 64'(bus.B_out), 64'(m_b));
                chk("x_out", 64'(bus.X_out), 64'(m_x));
            end
        end
    end

    task automatic load_b(input logic [W-1:0] v);
        bus.Load_B = 1'b1;
        bus.Din    = v;
        @(posedge clk); #1;
        bus.Load_B = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.Done && lat < 4*W) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic mult(input string nm, input logic [W-1:0] b, input logic [W-1:0] s,
                        input logic sm, input logic [2*W-1:0] exp_ab, input logic exp_x);
        int lat;
        load_b(b);
        bus.Start       = 1'b1;
        bus.Din         = s;
        bus.Signed_Mode = sm;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Din   = ~s;
        wait_done(lat);
        chk({nm, "_latency"}, 64'(lat), 64'(2*W));
        chk({nm, "_product"}, 64'({bus.A_out, bus.B_out}), 64'(exp_ab));
        chk({nm, "_x"}, 64'(bus.X_out), 64'(exp_x));
        @(posedge clk); #1;
        chk({nm, "_idle"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic rm;
        bus.Din = '0; bus.Load_B = 1'b0; bus.Clr_A = 1'b0;
        bus.Start = 1'b0; bus.Signed_Mode = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_ab", 64'({bus.X_out, bus.A_out, bus.B_out}), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        mult("s_m3x7",     8'hFD, 8'h07, 1'b1, 16'hFFEB, 1'b1);
        mult("u_3x200",    8'd3,  8'd200, 1'b0, 16'h0258, 1'b0);
        mult("u_ffxff",    8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
        mult("s_80x80",    8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
        mult("s_80x01",    8'h80, 8'h01, 1'b1, 16'hFF80, 1'b1);
        mult("s_m1xm1",    8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
        mult("u_zero",     8'h00, 8'hA7, 1'b0, 16'h0000, 1'b0);

        // Clr_A and Load_B together in IDLE
        bus.Clr_A = 1'b1;
        load_b(8'h3C);
        bus.Clr_A = 1'b0;
        chk("clr_load", 64'({bus.X_out, bus.A_out, bus.B_out}), 64'h0003C);

        // Start held across HOLD: no restart, product stable
        load_b(8'h05);
        bus.Start = 1'b1; bus.Din = 8'h06; bus.Signed_Mode = 1'b0;
        @(posedge clk); #1;
        wait_done(lat);
        chk("hold_latency", 64'(lat), 64'(2*W));
        repeat (10) @(posedge clk);
        #1;
        chk("hold_done", 64'(bus.Done), 64'd1);
        chk("hold_busy", 64'(bus.Busy), 64'd0);
        chk("hold_product", 64'({bus.A_out, bus.B_out}), 64'h001E);
        bus.Start = 1'b0;
        @(posedge clk); #1;
        chk("hold_release", 64'(bus.Done), 64'd0);

        // Load_B / Clr_A / mode changes while busy are ignored
        load_b(8'h0B);
        bus.Start = 1'b1; bus.Din = 8'h0D; bus.Signed_Mode = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.Load_B = 1'b1; bus.Clr_A = 1'b1; bus.Din = 8'hFF; bus.Signed_Mode = 1'b0;
        @(posedge clk); #1;
        bus.Load_B = 1'b0; bus.Clr_A = 1'b0;
        wait_done(lat);
        chk("busy_ignore_product", 64'({bus.A_out, bus.B_out}), 64'h008F);
        @(posedge clk); #1;

        // Asynchronous reset mid-run
        load_b(8'h09);
        bus.Start = 1'b1; bus.Din = 8'h07; bus.Signed_Mode = 1'b0;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_xab", 64'({bus.X_out, bus.A_out, bus.B_out}), 64'd0);
        chk("abort_busy", 64'(bus.Busy), 64'd0);
        chk("abort_done", 64'(bus.Done), 64'd0);
        @(posedge clk); #1;
        chk("abort_still_idle", 64'(bus.Busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mult("after_reset", 8'h09, 8'h07, 1'b0, 16'h003F, 1'b0);

        // Random operands in both modes
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom_range(1, 0));
            mult("random", rb, ra, rm, ref_prod(ra, rb, rm), rm & ref_prod(ra, rb, rm)[2*W-1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
